cpu_step_controller: RTL and testbench
======================================

Name: cpu_step_controller

Overview:
- Sequencer for the single-cycle 8-bit datapath.
- Produces a one-cycle clock-enable pulse `cpu_en` for the PC, register file and data memory, all on the system clock.
- Two modes: single-step from the debounced pushbutton, or free-run at a divided rate.
- Stops on a PC breakpoint or a HALT opcode. Exposes state, halt cause and retired-instruction count for display and debug probes.

Parameters:
- PC_W, 8, program counter width.
- OPCODE_W, 4, opcode field width.
- HALT_OPCODE, 4'hF, opcode that stops execution.
- RUN_DIV, 25_000_000, clk cycles between run-mode pulses (minimum 2).
- CNT_W, 16, cycle_count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- step_btn  in  1  debounced step pushbutton, level.
- run_sw  in  1  1 = free-run requested.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current PC from the datapath.
- opcode  in  OPCODE_W  opcode of the current instruction.
- cpu_en  out  1  one-cycle execute enable to the datapath sequential elements.
- state  out  2  FSM state: IDLE=0, STEP=1, RUN=2, HALT=3.
- halted  out  1  high in HALT.
- halt_cause  out  2  NONE=0, BREAK=1, HALTOP=2.
- cycle_count  out  CNT_W  number of cpu_en pulses issued.

Behaviour:
- Reset (async, immediate): state=IDLE, cpu_en=0, halted=0, halt_cause=NONE, cycle_count=0, divider=0, step edge register=0.
- Step edge: `edge = step_btn & ~step_q`, where `step_q` is the registered step_btn.
- Bounded pulse: a held button produces exactly one edge.
- cpu_en is registered and high for exactly one clk cycle per issued instruction. It is never high for two consecutive cycles.
- IDLE:
  - run_sw=1 -> RUN. Divider cleared, skip_bp set. A simultaneous edge is dropped; RUN wins.
  - else edge with opcode==HALT_OPCODE -> HALT, cause HALTOP, no pulse.
  - else edge -> STEP, with cpu_en=1 in the following cycle.
  - Latency: edge sampled at posedge k -> cpu_en high from k to k+1.
- STEP: one cycle only, then -> IDLE. Breakpoints are ignored when stepping.
- RUN:
  - run_sw=0 -> IDLE. Divider cleared, no pulse.
  - The divider counts 0..RUN_DIV-1. At terminal count (divider==RUN_DIV-1) it evaluates, in priority order:
    1. opcode==HALT_OPCODE -> HALT, cause HALTOP.
    2. bp_en & pc==bp_addr & ~skip_bp -> HALT, cause BREAK.
    3. otherwise issue cpu_en and clear skip_bp.
  - The divider wraps to 0 after terminal count.
  - skip_bp lets execution resume past the breakpoint the machine is currently sitting on.
- HALT:
  - cause BREAK: exit to IDLE on edge while run_sw=0. halt_cause returns to NONE and no pulse is issued. An edge with run_sw=1 is ignored.
  - cause HALTOP: sticky until rst.
- cycle_count increments on each cpu_en pulse. It wraps modulo 2^CNT_W.
- bp/opcode/pc are sampled only at decision points. Mid-interval changes have no effect.
- Reset mid-pulse forces cpu_en low asynchronously. Count and state are lost.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings and halt_cause encodings as typedef enums;
  - HALT_OPCODE default;
  - DIV_W derived as $clog2(RUN_DIV).
- One sub-module, run_tick_gen: a divider with synchronous clear that outputs a terminal-count strobe. The FSM and edge detection stay in the top.

Test Plan (RUN_DIV=4, opcode≠0xF unless stated):
1. Reset, then step_btn held high 10 cycles -> exactly one cpu_en pulse, one cycle after the first sampled high. cycle_count=1, state back to IDLE.
2. run_sw=1 for 20 cycles -> cpu_en on every 4th cycle (5 pulses). cycle_count=5. Dropping run_sw -> IDLE, no further pulses.
3. Breakpoint:
   - bp_en=1, bp_addr=0x06, running while pc advances 0x03 -> 0x06 -> HALT, cause BREAK, no pulse at pc 0x06.
   - Then run_sw=0 plus a step edge -> IDLE.
   - Then run_sw=1 -> first pulse issued at pc 0x06.
4. opcode=0xF at pc 0x09 in RUN -> HALT, cause HALTOP, no pulse. Step edges and run_sw toggles are ignored. Only rst returns to IDLE with cycle_count=0.
5. Step edge and run_sw rising in the same cycle from IDLE -> RUN, no immediate pulse. First pulse after 4 cycles.
6. Assert rst during the cpu_en high cycle -> cpu_en falls without waiting for a clock edge. All outputs at reset values. cycle_count=0xFFFF plus one pulse -> 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU step controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE   = 2'd0,
        HC_BREAK  = 2'd1,
        HC_HALTOP = 2'd2
    } halt_cause_t;

    localparam int unsigned RUN_DIV_DEF     = 25_000_000;
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;

    // Counter width able to hold 0..div-1; never narrower than one bit.
    function automatic int unsigned div_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    localparam int unsigned DIV_W = div_width(RUN_DIV_DEF);

endpackage

// File: rtl/cpu_step_if.sv
// Control/status bundle between the step controller and the datapath/debug side.
interface cpu_step_if #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned CNT_W    = 16
);
    logic                step_btn;
    logic                run_sw;
    logic                bp_en;
    logic [PC_W-1:0]     bp_addr;
    logic [PC_W-1:0]     pc;
    logic [OPCODE_W-1:0] opcode;
    logic                cpu_en;
    logic [1:0]          state;
    logic                halted;
    logic [1:0]          halt_cause;
    logic [CNT_W-1:0]    cycle_count;

    // Controller side.
    modport master (
        input  step_btn, run_sw, bp_en, bp_addr, pc, opcode,
        output cpu_en, state, halted, halt_cause, cycle_count
    );

    // Datapath / front-panel side.
    modport slave (
        output step_btn, run_sw, bp_en, bp_addr, pc, opcode,
        input  cpu_en, state, halted, halt_cause, cycle_count
    );
endinterface

// File: rtl/cpu_step_controller_run_tick_gen.sv
// Free-run rate divider: counts 0..DIV-1 while enabled and flags terminal count.
module run_tick_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV = RUN_DIV_DEF,
    parameter int unsigned W   = DIV_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = i_en & (r_cnt == TC);

    // Divider register: clear wins over count, wraps after terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TC) ? '0 : r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/cpu_step_controller.sv
// Execute-enable sequencer for the single-cycle 8-bit CPU.
//
//  state | meaning
//  ------+------------------------------------------------------------------
//  IDLE  | waiting for a step edge or run_sw
//  STEP  | cpu_en high for this single cycle, then back to IDLE
//  RUN   | free-run; one issue/halt decision per divider terminal count
//  HALT  | stopped; BREAK leaves on step edge with run_sw=0, HALTOP only on rst
module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned          PC_W        = 8,
    parameter int unsigned          OPCODE_W    = 4,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = OPCODE_W'(HALT_OPCODE_DEF),
    parameter int unsigned          RUN_DIV     = RUN_DIV_DEF,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    cpu_step_if.master bus
);
    localparam int unsigned DW = div_width(RUN_DIV);

    state_t              r_state, w_state_nxt;
    halt_cause_t         r_halt_cause, w_halt_cause_nxt;
    logic                r_skip_bp, w_skip_bp_nxt;
    logic                r_cpu_en, w_cpu_en_nxt;
    logic                r_step_q;
    logic [CNT_W-1:0]    r_cycle_count;

    logic                w_edge;
    logic                w_tick;
    logic                w_div_clr;
    logic                w_div_en;
    logic                w_is_halt_op;
    logic                w_bp_hit;
    logic [PC_W-1:0]     w_pc;
    logic [PC_W-1:0]     w_bp_addr;
    logic [OPCODE_W-1:0] w_opcode;

    assign w_pc         = bus.pc;
    assign w_bp_addr    = bus.bp_addr;
    assign w_opcode     = bus.opcode;
    assign w_edge       = bus.step_btn & ~r_step_q;
    assign w_is_halt_op = (w_opcode == HALT_OPCODE);
    // skip_bp lets a resumed run step off the breakpoint it stopped on.
    assign w_bp_hit     = bus.bp_en & (w_pc == w_bp_addr) & ~r_skip_bp;
    assign w_div_en     = (r_state == ST_RUN);

    run_tick_gen #(
        .DIV (RUN_DIV),
        .W   (DW)
    ) u_run_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_div_clr),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    // Next-state and issue decision; bp/opcode/pc only matter at decision points.
    always_comb begin
        w_state_nxt      = r_state;
        w_halt_cause_nxt = r_halt_cause;
        w_skip_bp_nxt    = r_skip_bp;
        w_cpu_en_nxt     = 1'b0;
        w_div_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run_sw) begin
                    // run_sw beats a simultaneous step edge.
                    w_state_nxt   = ST_RUN;
                    w_div_clr     = 1'b1;
                    w_skip_bp_nxt = 1'b1;
                end else if (w_edge) begin
                    if (w_is_halt_op) begin
                        w_state_nxt      = ST_HALT;
                        w_halt_cause_nxt = HC_HALTOP;
                    end else begin
                        w_state_nxt  = ST_STEP;
                        w_cpu_en_nxt = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (!bus.run_sw) begin
                    w_state_nxt = ST_IDLE;
                    w_div_clr   = 1'b1;
                end else if (w_tick) begin
                    if (w_is_halt_op) begin
                        w_state_nxt      = ST_HALT;
                        w_halt_cause_nxt = HC_HALTOP;
                    end else if (w_bp_hit) begin
                        w_state_nxt      = ST_HALT;
                        w_halt_cause_nxt = HC_BREAK;
                    end else begin
                        w_cpu_en_nxt  = 1'b1;
                        w_skip_bp_nxt = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                if ((r_halt_cause == HC_BREAK) && w_edge && !bus.run_sw) begin
                    w_state_nxt      = ST_IDLE;
                    w_halt_cause_nxt = HC_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, registered enable and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_halt_cause  <= HC_NONE;
            r_skip_bp     <= 1'b0;
            r_cpu_en      <= 1'b0;
            r_step_q      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_halt_cause_nxt;
            r_skip_bp    <= w_skip_bp_nxt;
            r_cpu_en     <= w_cpu_en_nxt;
            r_step_q     <= bus.step_btn;
            if (w_cpu_en_nxt) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign bus.cpu_en      = r_cpu_en;
    assign bus.state       = r_state;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.halt_cause  = r_halt_cause;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: main instance RUN_DIV=4/CNT_W=16,
// second instance RUN_DIV=2/CNT_W=4 to reach the counter wrap quickly.
module tb_cpu_step_controller;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   pulses   = 0;
    int   pulses_w = 0;
    int   double_en = 0;
    int   n;

    cpu_step_if #(.PC_W(8), .OPCODE_W(4), .CNT_W(16)) bm ();
    cpu_step_if #(.PC_W(8), .OPCODE_W(4), .CNT_W(4))  bw ();

    cpu_step_controller #(
        .PC_W(8), .OPCODE_W(4), .HALT_OPCODE(4'hF), .RUN_DIV(4), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    cpu_step_controller #(
        .PC_W(8), .OPCODE_W(4), .HALT_OPCODE(4'hF), .RUN_DIV(2), .CNT_W(4)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    always #5 clk = ~clk;

    // One clock; the datapath model advances pc on edges where cpu_en was high.
    task automatic tick();
        logic en_m, en_w;
        en_m = bm.cpu_en;
        en_w = bw.cpu_en;
        @(posedge clk);
        #1;
        if (en_m) bm.pc = bm.pc + 8'd1;
        if (en_w) bw.pc = bw.pc + 8'd1;
        if (bm.cpu_en) begin
            pulses++;
            if (en_m) double_en++;
        end
        if (bw.cpu_en) pulses_w++;
    endtask

    task automatic clear_inputs();
        bm.step_btn = 0; bm.run_sw = 0; bm.bp_en = 0; bm.bp_addr = 0; bm.opcode = 0; bm.pc = 0;
        bw.step_btn = 0; bw.run_sw = 0; bw.bp_en = 0; bw.bp_addr = 0; bw.opcode = 0; bw.pc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        pulses = 0; pulses_w = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bm.state); end
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b expected 0", bm.cpu_en); end
        checks++; if (bm.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", bm.halted); end
        checks++; if (bm.halt_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d expected 0", bm.halt_cause); end
        checks++; if (bm.cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", bm.cycle_count); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_step();
        do_reset();
        bm.step_btn = 1;
        tick();
        checks++; if (bm.cpu_en !== 1'b1) begin errors++; $display("FAIL step_latency: got %0b expected 1", bm.cpu_en); end
        checks++; if (bm.state !== 2'd1) begin errors++; $display("FAIL step_state: got %0d expected 1", bm.state); end
        repeat (9) tick();
        checks++; if (pulses !== 1) begin errors++; $display("FAIL step_held_pulses: got %0d expected 1", pulses); end
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL step_back_idle: got %0d expected 0", bm.state); end
        checks++; if (bm.cycle_count !== 16'd1) begin errors++; $display("FAIL step_count: got %0h expected 1", bm.cycle_count); end
        bm.step_btn = 0; tick();
        bm.step_btn = 1; tick();
        bm.step_btn = 0; tick();
        checks++; if (bm.cycle_count !== 16'd2) begin errors++; $display("FAIL step_second_press: got %0h expected 2", bm.cycle_count); end
    endtask

    task automatic test_step_haltop();
        do_reset();
        bm.opcode = 4'hF;
        bm.step_btn = 1;
        tick();
        checks++; if (bm.state !== 2'd3) begin errors++; $display("FAIL step_haltop_state: got %0d expected 3", bm.state); end
        checks++; if (bm.halt_cause !== 2'd2) begin errors++; $display("FAIL step_haltop_cause: got %0d expected 2", bm.halt_cause); end
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL step_haltop_nopulse: got %0b expected 0", bm.cpu_en); end
        checks++; if (bm.cycle_count !== 16'd0) begin errors++; $display("FAIL step_haltop_count: got %0h expected 0", bm.cycle_count); end
        bm.step_btn = 0; bm.opcode = 0;
        tick();
    endtask

    task automatic test_run();
        logic exp_en;
        do_reset();
        bm.run_sw = 1;
        tick();
        checks++; if (bm.state !== 2'd2) begin errors++; $display("FAIL run_enter: got %0d expected 2", bm.state); end
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL run_enter_nopulse: got %0b expected 0", bm.cpu_en); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_en = (i % 4 == 0);
            checks++; if (bm.cpu_en !== exp_en) begin errors++; $display("FAIL run_cadence cycle %0d: got %0b expected %0b", i, bm.cpu_en, exp_en); end
        end
        checks++; if (pulses !== 5) begin errors++; $display("FAIL run_pulses: got %0d expected 5", pulses); end
        checks++; if (bm.cycle_count !== 16'd5) begin errors++; $display("FAIL run_count: got %0h expected 5", bm.cycle_count); end
        bm.run_sw = 0;
        tick();
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL run_exit: got %0d expected 0", bm.state); end
        repeat (10) tick();
        checks++; if (pulses !== 5) begin errors++; $display("FAIL run_exit_quiet: got %0d expected 5", pulses); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bm.pc = 8'h03; bm.bp_en = 1; bm.bp_addr = 8'h06;
        bm.run_sw = 1;
        tick();
        n = 0;
        while (bm.state !== 2'd3 && n < 40) begin tick(); n++; end
        checks++; if (bm.state !== 2'd3) begin errors++; $display("FAIL bp_halt_state: got %0d expected 3", bm.state); end
        checks++; if (bm.halt_cause !== 2'd1) begin errors++; $display("FAIL bp_cause: got %0d expected 1", bm.halt_cause); end
        checks++; if (bm.halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %0b expected 1", bm.halted); end
        checks++; if (bm.pc !== 8'h06) begin errors++; $display("FAIL bp_pc: got %0h expected 06", bm.pc); end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL bp_pulses: got %0d expected 3", pulses); end
        bm.step_btn = 1;
        tick();
        checks++; if (bm.state !== 2'd3) begin errors++; $display("FAIL bp_edge_run_ignored: got %0d expected 3", bm.state); end
        bm.step_btn = 0; bm.run_sw = 0;
        tick();
        bm.step_btn = 1;
        tick();
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL bp_exit_state: got %0d expected 0", bm.state); end
        checks++; if (bm.halt_cause !== 2'd0) begin errors++; $display("FAIL bp_exit_cause: got %0d expected 0", bm.halt_cause); end
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL bp_exit_nopulse: got %0b expected 0", bm.cpu_en); end
        bm.step_btn = 0;
        pulses = 0;
        bm.run_sw = 1;
        tick();
        repeat (4) tick();
        checks++; if (bm.cpu_en !== 1'b1) begin errors++; $display("FAIL bp_resume_pulse: got %0b expected 1", bm.cpu_en); end
        checks++; if (bm.pc !== 8'h06) begin errors++; $display("FAIL bp_resume_pc: got %0h expected 06", bm.pc); end
        tick();
        checks++; if (bm.pc !== 8'h07) begin errors++; $display("FAIL bp_resume_advance: got %0h expected 07", bm.pc); end
        bm.run_sw = 0;
        tick();
    endtask

    task automatic test_haltop();
        do_reset();
        bm.pc = 8'h07;
        bm.run_sw = 1;
        tick();
        n = 0;
        while (bm.state !== 2'd3 && n < 40) begin
            tick();
            bm.opcode = (bm.pc == 8'h09) ? 4'hF : 4'h0;
            n++;
        end
        checks++; if (bm.state !== 2'd3) begin errors++; $display("FAIL haltop_state: got %0d expected 3", bm.state); end
        checks++; if (bm.halt_cause !== 2'd2) begin errors++; $display("FAIL haltop_cause: got %0d expected 2", bm.halt_cause); end
        checks++; if (bm.pc !== 8'h09) begin errors++; $display("FAIL haltop_pc: got %0h expected 09", bm.pc); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL haltop_pulses: got %0d expected 2", pulses); end
        for (int i = 0; i < 8; i++) begin
            bm.step_btn = i[0];
            bm.run_sw   = i[1];
            tick();
        end
        checks++; if (bm.state !== 2'd3) begin errors++; $display("FAIL haltop_sticky_state: got %0d expected 3", bm.state); end
        checks++; if (bm.halt_cause !== 2'd2) begin errors++; $display("FAIL haltop_sticky_cause: got %0d expected 2", bm.halt_cause); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL haltop_sticky_pulses: got %0d expected 2", pulses); end
        rst = 1'b1;
        #1;
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL haltop_rst_state: got %0d expected 0", bm.state); end
        checks++; if (bm.cycle_count !== 16'd0) begin errors++; $display("FAIL haltop_rst_count: got %0h expected 0", bm.cycle_count); end
        checks++; if (bm.halt_cause !== 2'd0) begin errors++; $display("FAIL haltop_rst_cause: got %0d expected 0", bm.halt_cause); end
        bm.step_btn = 0; bm.run_sw = 0; bm.opcode = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic exp_en;
        do_reset();
        bm.step_btn = 1; bm.run_sw = 1;
        tick();
        checks++; if (bm.state !== 2'd2) begin errors++; $display("FAIL simul_state: got %0d expected 2", bm.state); end
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL simul_nopulse: got %0b expected 0", bm.cpu_en); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_en = (i == 4);
            checks++; if (bm.cpu_en !== exp_en) begin errors++; $display("FAIL simul_first_pulse cycle %0d: got %0b expected %0b", i, bm.cpu_en, exp_en); end
        end
        bm.run_sw = 0; bm.step_btn = 0;
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        bm.step_btn = 1;
        tick();
        checks++; if (bm.cpu_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_pulse: got %0b expected 1", bm.cpu_en); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bm.cpu_en !== 1'b0) begin errors++; $display("FAIL midrst_cpu_en: got %0b expected 0", bm.cpu_en); end
        checks++; if (bm.state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", bm.state); end
        checks++; if (bm.cycle_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0h expected 0", bm.cycle_count); end
        bm.step_btn = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_count_wrap();
        do_reset();
        bw.run_sw = 1;
        n = 0;
        while (pulses_w < 15 && n < 100) begin tick(); n++; end
        checks++; if (bw.cycle_count !== 4'hF) begin errors++; $display("FAIL wrap_full: got %0h expected f", bw.cycle_count); end
        n = 0;
        while (pulses_w < 16 && n < 10) begin tick(); n++; end
        checks++; if (bw.cpu_en !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %0b expected 1", bw.cpu_en); end
        checks++; if (bw.cycle_count !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %0h expected 0", bw.cycle_count); end
        bw.run_sw = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_step();
        test_step_haltop();
        test_run();
        test_breakpoint();
        test_haltop();
        test_simultaneous();
        test_reset_mid_pulse();
        test_count_wrap();
        checks++; if (double_en !== 0) begin errors++; $display("FAIL cpu_en_back_to_back: got %0d expected 0", double_en); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
